write_arbiter_rr: RTL and testbench

- Clocked, parametrised successor to the 3-core write-enable arbiter in the multi-core logic unit.
- Accepts write requests from N_CH logic cores and issues exactly one write token at a time, using round-robin fairness.
- Each grant is held until the owner finishes, withdraws, or times out.
- Sits between the core array and the shared output/result word, so that one core drives the bus per transaction.

---
 rtl/write_arbiter_rr.sv | 131 +++++++++++++
 tb/tb_write_arbiter_rr.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/write_arbiter_rr.sv
//------------------------------------------------------------------------------
// Module      : write_arbiter_rr
// Description : Round-robin write-token arbiter with hold timeout and a dead
//               cycle between consecutive owners.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module write_arbiter_rr #(
    parameter int N_CH     = 3,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4,
    parameter int ID_W     = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_CH-1:0]   WE,
    input  logic [N_CH-1:0]   WR_DONE,
    output logic [N_CH-1:0]   WT,
    output logic [ID_W-1:0]   GNT_ID,
    output logic              BUSY,
    output logic              TO_ERR
);

    localparam logic [1:0]       c_idle  = 2'd0;
    localparam logic [1:0]       c_grant = 2'd1;
    localparam logic [1:0]       c_gap   = 2'd2;
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]  c_top   = ID_W'(N_CH - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [N_CH-1:0] r_wt;
    logic [N_CH-1:0] w_wt_nxt;
    logic [ID_W-1:0] r_gnt;
    logic [ID_W-1:0] w_gnt_nxt;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic            r_to_err;
    logic            w_to_nxt;
    logic [ID_W-1:0] w_sel;
    logic            w_found;
    logic            w_own_done;
    logic            w_own_we;
    logic            w_tmo;
    logic            w_release;

    // Scan requests starting at the pointer and wrapping; first set bit wins.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!w_found && WE[(int'(r_ptr) + k) % N_CH]) begin
                w_found = 1'b1;
                w_sel   = ID_W'((int'(r_ptr) + k) % N_CH);
            end
        end
    end

    // The token register is one-hot on the owner, so it masks owner-only bits.
    assign w_own_done = |(WR_DONE & r_wt);
    assign w_own_we   = |(WE & r_wt);
    assign w_tmo      = (r_cnt == c_last);
    assign w_release  = w_own_done | ~w_own_we | w_tmo;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= c_idle;
            r_wt     <= '0;
            r_gnt    <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wt     <= w_wt_nxt;
            r_gnt    <= w_gnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_to_err <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_found) w_state_nxt = c_grant;
            c_grant: if (w_release) w_state_nxt = c_gap;
            c_gap:   w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        w_wt_nxt  = '0;
        w_gnt_nxt = '0;
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = '0;
        w_to_nxt  = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_found) begin
                    w_wt_nxt  = N_CH'(1) << w_sel;
                    w_gnt_nxt = w_sel;
                end
            end
            c_grant: begin
                if (w_release) begin
                    w_ptr_nxt = (r_gnt == c_top) ? '0 : r_gnt + 1'b1;
                    // Timeout flags an error only when nothing else released.
                    w_to_nxt  = ~w_own_done & w_own_we & w_tmo;
                end else begin
                    w_wt_nxt  = r_wt;
                    w_gnt_nxt = r_gnt;
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign WT     = r_wt;
    assign GNT_ID = r_gnt;
    assign BUSY   = |r_wt;
    assign TO_ERR = r_to_err;

endmodule

`default_nettype wire

// File: tb/tb_write_arbiter_rr.sv
//------------------------------------------------------------------------------
// Module      : tb_write_arbiter_rr
// Description : Directed vector bench for write_arbiter_rr (N_CH=3, MAX_HOLD=8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_write_arbiter_rr;

    typedef struct {
        logic       rst;
        logic [2:0] we;
        logic [2:0] done;
        logic [2:0] wt;
        logic [1:0] gnt;
        logic       busy;
        logic       to;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] we;
    logic [2:0] wr_done;
    logic [2:0] wt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       to_err;
    logic       r_prev_to;

    int   checks;
    int   failures;
    vec_t tbl[$];

    write_arbiter_rr #(
        .N_CH     (3),
        .MAX_HOLD (8),
        .CNT_W    (4),
        .ID_W     (2)
    ) u_dut (
        .CLK     (clk),
        .RST     (rst),
        .WE      (we),
        .WR_DONE (wr_done),
        .WT      (wt),
        .GNT_ID  (gnt_id),
        .BUSY    (busy),
        .TO_ERR  (to_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [2:0] w, input logic [2:0] d,
                       input logic [2:0] ewt, input logic [1:0] eg,
                       input logic eb, input logic et);
        vec_t v;
        v.rst = r; v.we = w; v.done = d; v.wt = ewt; v.gnt = eg; v.busy = eb; v.to = et;
        tbl.push_back(v);
    endtask

    // Apply inputs across one rising edge, then check the registered outputs.
    task automatic step(input logic r, input logic [2:0] w, input logic [2:0] d,
                        input logic [2:0] ewt, input logic [1:0] eg,
                        input logic eb, input logic et, input string name);
        rst = r; we = w; wr_done = d;
        r_prev_to = to_err;
        @(posedge clk);
        #1;
        checks++;
        if ({wt, gnt_id, busy, to_err} !== {ewt, eg, eb, et}) begin
            failures++;
            $display("FAIL %s: got wt=%b gnt=%0d busy=%b to=%b, want wt=%b gnt=%0d busy=%b to=%b",
                     name, wt, gnt_id, busy, to_err, ewt, eg, eb, et);
        end
        checks++;
        if ((wt & (wt - 3'd1)) != 3'd0 || busy !== |wt || (to_err && r_prev_to)) begin
            failures++;
            $display("FAIL %s_inv: got wt=%b busy=%b to=%b prev_to=%b, want onehot0 wt, busy=|wt, no double to",
                     name, wt, busy, to_err, r_prev_to);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; we = 3'b000; wr_done = 3'b000; r_prev_to = 1'b0;

        //   rst we      done    wt      gnt  busy to
        add(1, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
        add(1, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
        add(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
        add(0, 3'b010, 3'b000, 3'b010, 2'd1, 1, 0);   // single request
        add(0, 3'b010, 3'b000, 3'b010, 2'd1, 1, 0);
        add(0, 3'b010, 3'b010, 3'b000, 2'd0, 0, 0);   // done -> release
        add(0, 3'b010, 3'b000, 3'b000, 2'd0, 0, 0);   // gap
        add(0, 3'b010, 3'b000, 3'b010, 2'd1, 1, 0);   // re-grant
        add(0, 3'b010, 3'b101, 3'b010, 2'd1, 1, 0);   // non-owner done ignored
        add(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);   // withdraw
        add(0, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0);   // gap ignores requests
        add(0, 3'b111, 3'b000, 3'b100, 2'd2, 1, 0);   // ptr advanced to 2
        add(0, 3'b111, 3'b100, 3'b000, 2'd0, 0, 0);
        add(0, 3'b111, 3'b111, 3'b000, 2'd0, 0, 0);   // done in gap ignored
        add(0, 3'b111, 3'b000, 3'b001, 2'd0, 1, 0);   // ptr wrapped to 0
        add(0, 3'b111, 3'b001, 3'b000, 2'd0, 0, 0);
        add(0, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0);
        add(0, 3'b111, 3'b010, 3'b010, 2'd1, 1, 0);   // done in idle ignored
        add(0, 3'b111, 3'b010, 3'b000, 2'd0, 0, 0);
        add(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
        add(0, 3'b100, 3'b000, 3'b100, 2'd2, 1, 0);
        add(1, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0);   // reset mid-grant
        add(0, 3'b111, 3'b000, 3'b001, 2'd0, 1, 0);   // post-reset scan from 0
        add(0, 3'b111, 3'b001, 3'b000, 2'd0, 0, 0);
        add(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
        add(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
        add(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
        add(0, 3'b001, 3'b000, 3'b001, 2'd0, 1, 0);   // ptr=1, only core 0
        add(0, 3'b101, 3'b000, 3'b001, 2'd0, 1, 0);   // core 2 requests briefly
        add(0, 3'b001, 3'b001, 3'b000, 2'd0, 0, 0);
        add(0, 3'b001, 3'b000, 3'b000, 2'd0, 0, 0);
        add(0, 3'b001, 3'b000, 3'b001, 2'd0, 1, 0);   // core 2 request was lost
        add(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
        add(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);

        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].we, tbl[i].done, tbl[i].wt, tbl[i].gnt,
                 tbl[i].busy, tbl[i].to, $sformatf("vec%0d", i));

        // Round-robin with all cores requesting; each owner finishes on its 2nd cycle.
        step(1, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0, "rr_rst");
        for (int r = 0; r < 4; r++) begin
            logic [2:0] oh;
            logic [1:0] g;
            g  = 2'(r % 3);
            oh = 3'b001 << g;
            step(0, 3'b111, 3'b000, oh,     g,    1, 0, $sformatf("rr%0d_grant", r));
            step(0, 3'b111, 3'b000, oh,     g,    1, 0, $sformatf("rr%0d_hold", r));
            step(0, 3'b111, oh,     3'b000, 2'd0, 0, 0, $sformatf("rr%0d_rel", r));
            step(0, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0, $sformatf("rr%0d_gap", r));
        end

        // Timeout: token held exactly 8 cycles, then one-cycle TO_ERR.
        step(1, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0, "to_rst");
        for (int c = 0; c < 8; c++)
            step(0, 3'b001, 3'b000, 3'b001, 2'd0, 1, 0, $sformatf("to_hold%0d", c));
        step(0, 3'b001, 3'b000, 3'b000, 2'd0, 0, 1, "to_release");
        step(0, 3'b001, 3'b000, 3'b000, 2'd0, 0, 0, "to_gap");
        step(0, 3'b001, 3'b000, 3'b001, 2'd0, 1, 0, "to_regrant");

        // Done on the 8th held cycle wins over timeout.
        for (int c = 1; c < 8; c++)
            step(0, 3'b001, 3'b000, 3'b001, 2'd0, 1, 0, $sformatf("dt_hold%0d", c));
        step(0, 3'b001, 3'b001, 3'b000, 2'd0, 0, 0, "dt_release");
        step(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0, "dt_gap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
